writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 5, meaning the register index width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 64, meaning the register and data width.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream (memory stage) presents a retiring instruction.
REQ-006 in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 in_wb_en  in  1  instruction writes a destination register.
REQ-008 in_rd  in  ADDR_WIDTH  destination register index.
REQ-009 in_is_load  in  1  select load data instead of ALU result.
REQ-010 in_funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU.
REQ-011 in_addr_lo  in  3  low 3 bits of load address (byte lane).
REQ-012 in_alu_result  in  DATA_WIDTH  execute result.
REQ-013 in_mem_data  in  DATA_WIDTH  aligned 64-bit doubleword read from memory.
REQ-014 wb_hold  in  1  freeze draining (register file port unavailable).
REQ-015 rf_write_enable  out  1  register file write strobe.
REQ-016 rf_write_addr  out  ADDR_WIDTH  register file write index.
REQ-017 rf_write_data  out  DATA_WIDTH  register file write data.
REQ-018 rf_reset_write_addr  out  ADDR_WIDTH  index whose busy bit is cleared; 0 when idle.
REQ-019 retire_count  out  64  count of instructions retired.
REQ-020 fwd_valid / fwd_rd / fwd_data  out  1 / ADDR_WIDTH / DATA_WIDTH  forwarding view (see Configuration).

Function
REQ-021 Accepted instructions SHALL enter a 2-entry FIFO; in_ready = (occupancy < 2), registered-free, independent of in_valid.
REQ-022 When FIFO non-empty and wb_hold=0, the head SHALL be popped at the next edge and its result registered onto rf_* outputs for exactly one cycle.
REQ-023 Latency: instruction accepted at edge E into empty FIFO with wb_hold=0 SHALL drive rf_write_enable during cycle after E+1 (two edges).
REQ-024 Simultaneous push and pop SHALL keep occupancy unchanged; throughput one instruction per cycle.
REQ-025 Load data SHALL be in_mem_data >> (8*in_addr_lo), then sign-extended (funct3 0,1,2) or zero-extended (4,5,6) from 8/16/32 bits; funct3 3 passes 64 bits; funct3 7 yields 0.
REQ-026 Non-loads SHALL write in_alu_result unmodified.
REQ-027 rf_write_enable SHALL be 1 only if in_wb_en=1 and in_rd!=0; rf_write_addr/rf_write_data SHALL be 0 when not writing.
REQ-028 rf_reset_write_addr SHALL equal rf_write_addr on a write cycle, else 0.
REQ-029 retire_count SHALL increment by 1 per pop, including in_wb_en=0 and rd=0, wrapping at 2^64.
REQ-030 wb_hold=1 SHALL drive rf_* outputs to 0 and retain FIFO contents; pushes continue until full.

Reset
REQ-031 reset SHALL empty the FIFO, zero all rf_* and fwd_* outputs and retire_count, and force in_ready=0 during the reset cycle, 1 afterwards.
REQ-032 reset asserted mid-operation SHALL discard buffered instructions without any register-file write.

Configuration
REQ-033 With WB_FORWARD_EN defined, fwd_valid/fwd_rd/fwd_data SHALL combinationally mirror the FIFO head's pending write (valid if non-empty, in_wb_en, rd!=0, wb_hold irrelevant).
REQ-034 Without WB_FORWARD_EN, fwd_* SHALL be tied to 0 and no forwarding logic instantiated.

Verification
REQ-035 LB, in_addr_lo=3, in_mem_data=0x00000000_80FF0000 -> rf_write_data=0xFFFFFFFF_FFFFFF80... byte 3=0x80 -> 0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
REQ-036 ALU result 0x1234 to rd=5, wb_hold=0 -> rf_write_enable=1, addr 5, data 0x1234, rf_reset_write_addr=5, two edges after accept; retire_count=1.
REQ-037 rd=0 with in_wb_en=1 -> no write, rf_reset_write_addr=0, retire_count increments.
REQ-038 wb_hold=1 for 4 cycles while pushing 3 instructions -> in_ready=0 after 2 accepted; on release, 2 writes on consecutive cycles then third accepted.
REQ-039 reset asserted with 2 entries buffered -> no rf_write_enable afterwards, retire_count=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: 2-entry retire FIFO feeding one registered register-file write port.
// Optional macro WB_FORWARD_EN exposes the FIFO head's pending write on fwd_*.
module writeback_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wb_en,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [2:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  input  logic                  wb_hold,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_reset_write_addr,
  output logic [63:0]           retire_count,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic                  push_we_s;
  logic                  push_s;
  logic                  pop_s;

  logic                  entry_we_r   [2];
  logic [ADDR_WIDTH-1:0] entry_rd_r   [2];
  logic [DATA_WIDTH-1:0] entry_data_r [2];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            count_r;
  logic [1:0]            count_next_s;

  logic                  rf_we_r;
  logic [ADDR_WIDTH-1:0] rf_addr_r;
  logic [DATA_WIDTH-1:0] rf_data_r;
  logic [63:0]           retire_r;

  assign in_ready = !reset && (count_r < 2'd2);
  assign push_s   = in_valid && in_ready;
  assign pop_s    = (count_r != 2'd0) && !wb_hold;

  // Byte-lane alignment and sign/zero extension of load data
  always_comb begin
    shifted_s   = in_mem_data >> {in_addr_lo, 3'b000};
    load_data_s = {DATA_WIDTH{1'b0}};
    case (in_funct3)
      3'd0: load_data_s = {{(DATA_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
      3'd1: load_data_s = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
      3'd2: load_data_s = {{(DATA_WIDTH-32){shifted_s[31]}}, shifted_s[31:0]};
      3'd3: load_data_s = shifted_s;
      3'd4: load_data_s = {{(DATA_WIDTH-8){1'b0}}, shifted_s[7:0]};
      3'd5: load_data_s = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
      3'd6: load_data_s = {{(DATA_WIDTH-32){1'b0}}, shifted_s[31:0]};
      default: load_data_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Resolve write qualification and data before buffering, so the FIFO holds final values
  always_comb begin
    push_we_s = in_wb_en && (in_rd != {ADDR_WIDTH{1'b0}});
    if (!push_we_s) begin
      push_data_s = {DATA_WIDTH{1'b0}};
    end else if (in_is_load) begin
      push_data_s = load_data_s;
    end else begin
      push_data_s = in_alu_result;
    end
  end

  // Occupancy update; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r        <= 1'b0;
      rd_ptr_r        <= 1'b0;
      count_r         <= 2'd0;
      entry_we_r[0]   <= 1'b0;
      entry_we_r[1]   <= 1'b0;
      entry_rd_r[0]   <= {ADDR_WIDTH{1'b0}};
      entry_rd_r[1]   <= {ADDR_WIDTH{1'b0}};
      entry_data_r[0] <= {DATA_WIDTH{1'b0}};
      entry_data_r[1] <= {DATA_WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
      if (push_s) begin
        entry_we_r[wr_ptr_r]   <= push_we_s;
        entry_rd_r[wr_ptr_r]   <= push_we_s ? in_rd : {ADDR_WIDTH{1'b0}};
        entry_data_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r               <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Registered register-file port: live for exactly the cycle after a pop
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_r   <= 1'b0;
      rf_addr_r <= {ADDR_WIDTH{1'b0}};
      rf_data_r <= {DATA_WIDTH{1'b0}};
      retire_r  <= 64'd0;
    end else if (pop_s) begin
      rf_we_r   <= entry_we_r[rd_ptr_r];
      rf_addr_r <= entry_we_r[rd_ptr_r] ? entry_rd_r[rd_ptr_r] : {ADDR_WIDTH{1'b0}};
      rf_data_r <= entry_we_r[rd_ptr_r] ? entry_data_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
      retire_r  <= retire_r + 64'd1;
    end else begin
      rf_we_r   <= 1'b0;
      rf_addr_r <= {ADDR_WIDTH{1'b0}};
      rf_data_r <= {DATA_WIDTH{1'b0}};
    end
  end

  assign rf_write_enable     = rf_we_r;
  assign rf_write_addr       = rf_addr_r;
  assign rf_write_data       = rf_data_r;
  assign rf_reset_write_addr = rf_addr_r;
  assign retire_count        = retire_r;

`ifdef WB_FORWARD_EN
  // Forward the head's pending write; wb_hold does not hide it
  always_comb begin
    fwd_valid = !reset && (count_r != 2'd0) && entry_we_r[rd_ptr_r];
    if (fwd_valid) begin
      fwd_rd   = entry_rd_r[rd_ptr_r];
      fwd_data = entry_data_r[rd_ptr_r];
    end else begin
      fwd_rd   = {ADDR_WIDTH{1'b0}};
      fwd_data = {DATA_WIDTH{1'b0}};
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = {ADDR_WIDTH{1'b0}};
  assign fwd_data  = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a queue-based reference model predicts each cycle's outputs.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_wb_en, in_is_load, wb_hold;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3, in_addr_lo;
  logic [63:0] in_alu_result, in_mem_data;
  logic        rf_write_enable, fwd_valid;
  logic [4:0]  rf_write_addr, rf_reset_write_addr, fwd_rd;
  logic [63:0] rf_write_data, retire_count, fwd_data;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .wb_hold(wb_hold),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_reset_write_addr(rf_reset_write_addr),
    .retire_count(retire_count), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  typedef struct {
    logic        wb_en;
    logic [4:0]  rd;
    logic        ld;
    logic [2:0]  f3;
    logic [2:0]  a;
    logic [63:0] alu;
    logic [63:0] mem;
  } ins_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
  } item_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [63:0] retire;
  } exp_t;

  item_t       model_q [$];
  exp_t        exp_q [$];
  logic [63:0] model_retire = 64'd0;
  bit          run = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] ref_load(input logic [63:0] mem, input logic [2:0] f3,
                                           input logic [2:0] a);
    logic [63:0]        s;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    s = mem / (64'd1 << (8 * a));
    b = s[7:0];
    h = s[15:0];
    w = s[31:0];
    case (f3)
      3'd0:    return 64'(b);
      3'd1:    return 64'(h);
      3'd2:    return 64'(w);
      3'd3:    return s;
      3'd4:    return s % 64'd256;
      3'd5:    return s % 64'd65536;
      3'd6:    return s % 64'h1_0000_0000;
      default: return 64'd0;
    endcase
  endfunction

  // One cycle: drive inputs, check ready/forwarding, advance the model, queue the expected outputs
  task automatic step(input ins_t i, input logic v, input logic h, input logic r, output logic acc);
    exp_t  e;
    item_t it;
    logic  pop;
    reset = r; in_valid = v; wb_hold = h;
    in_wb_en = i.wb_en; in_rd = i.rd; in_is_load = i.ld; in_funct3 = i.f3;
    in_addr_lo = i.a; in_alu_result = i.alu; in_mem_data = i.mem;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!r && model_q.size() < 2)});
`ifdef WB_FORWARD_EN
    if (!r && model_q.size() > 0 && model_q[0].we) begin
      chk("fwd_valid", {63'd0, fwd_valid}, 64'd1);
      chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, model_q[0].rd});
      chk("fwd_data", fwd_data, model_q[0].data);
    end else begin
      chk("fwd_idle", {fwd_valid, fwd_rd, fwd_data}, 64'd0);
    end
`else
    chk("fwd_tied", {fwd_valid, fwd_rd, fwd_data}, 64'd0);
`endif
    e = '{we: 1'b0, addr: 5'd0, data: 64'd0, retire: 64'd0};
    acc = 1'b0;
    if (r) begin
      model_q.delete();
      model_retire = 64'd0;
    end else begin
      pop = (model_q.size() > 0) && !h;
      acc = v && (model_q.size() < 2);
      if (pop) begin
        it = model_q.pop_front();
        model_retire = model_retire + 64'd1;
        e.we = it.we;
        e.addr = it.rd;
        e.data = it.data;
      end
      if (acc) begin
        it.we = i.wb_en && (i.rd != 5'd0);
        it.rd = it.we ? i.rd : 5'd0;
        it.data = !it.we ? 64'd0 : (i.ld ? ref_load(i.mem, i.f3, i.a) : i.alu);
        model_q.push_back(it);
      end
    end
    e.retire = model_retire;
    exp_q.push_back(e);
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compares the DUT outputs just after every active edge against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rf_write_enable", {63'd0, rf_write_enable}, {63'd0, e.we});
          chk("rf_write_addr", {59'd0, rf_write_addr}, {59'd0, e.addr});
          chk("rf_write_data", rf_write_data, e.data);
          chk("rf_reset_write_addr", {59'd0, rf_reset_write_addr}, {59'd0, e.addr});
          chk("retire_count", retire_count, e.retire);
        end
      end
    end
  end

  initial begin
    ins_t nop, x, hq[3];
    logic acc;
    int   k;
    nop = '{wb_en: 1'b0, rd: 5'd0, ld: 1'b0, f3: 3'd0, a: 3'd0, alu: 64'd0, mem: 64'd0};
    step(nop, 1'b1, 1'b0, 1'b1, acc);
    step(nop, 1'b0, 1'b0, 1'b1, acc);
    step(nop, 1'b0, 1'b0, 1'b0, acc);

    // ALU write to rd=5, then idle
    x = nop; x.wb_en = 1'b1; x.rd = 5'd5; x.alu = 64'h1234;
    step(x, 1'b1, 1'b0, 1'b0, acc);
    repeat (3) step(nop, 1'b0, 1'b0, 1'b0, acc);

    // LB / LBU of byte lane 3 holding 0x80
    x = nop; x.wb_en = 1'b1; x.rd = 5'd7; x.ld = 1'b1; x.f3 = 3'd0; x.a = 3'd3;
    x.mem = 64'h0000_0000_80FF_0000; x.alu = 64'hDEAD;
    step(x, 1'b1, 1'b0, 1'b0, acc);
    x.f3 = 3'd4; x.rd = 5'd8;
    step(x, 1'b1, 1'b0, 1'b0, acc);
    // rd=0 with write enable retires without writing
    x = nop; x.wb_en = 1'b1; x.rd = 5'd0; x.alu = 64'h55;
    step(x, 1'b1, 1'b0, 1'b0, acc);
    repeat (3) step(nop, 1'b0, 1'b0, 1'b0, acc);

    // Hold for 4 cycles while offering 3 instructions, then release
    for (int j = 0; j < 3; j++) begin
      hq[j] = nop; hq[j].wb_en = 1'b1; hq[j].rd = 5'(10 + j); hq[j].alu = 64'(100 + j);
    end
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 3) begin
        step(hq[k], 1'b1, (c < 4), 1'b0, acc);
        if (acc) k++;
      end else begin
        step(nop, 1'b0, 1'b0, 1'b0, acc);
      end
    end
    chk("hold_all_accepted", 64'(k), 64'd3);

    // Reset with two entries buffered: nothing must be written afterwards
    x = nop; x.wb_en = 1'b1; x.rd = 5'd3; x.alu = 64'hAAAA;
    step(x, 1'b1, 1'b1, 1'b0, acc);
    x.rd = 5'd4;
    step(x, 1'b1, 1'b1, 1'b0, acc);
    step(nop, 1'b0, 1'b1, 1'b1, acc);
    repeat (4) step(nop, 1'b0, 1'b0, 1'b0, acc);

    // Randomized traffic with occasional hold and reset
    for (int c = 0; c < 600; c++) begin
      x.wb_en = ($urandom_range(0, 3) != 0);
      x.rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      x.ld    = $urandom_range(0, 1) == 1;
      x.f3    = 3'($urandom);
      x.a     = 3'($urandom);
      x.alu   = {$urandom, $urandom};
      x.mem   = {$urandom, $urandom};
      step(x, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 99) == 0), acc);
    end
    repeat (3) step(nop, 1'b0, 1'b0, 1'b0, acc);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
